// File: rtl/prim_reg_slice_pkg.sv
// Shared types and constants for the valid/ready register slice.
package prim_reg_slice_pkg;

  localparam int unsigned SliceDepth = 2;
  localparam int unsigned DepthW     = 2;

  typedef enum logic [1:0] {
    SliceEmpty = 2'b00,
    SliceOne   = 2'b01,
    SliceFull  = 2'b11
  } slice_state_e;

endpackage : prim_reg_slice_pkg

// File: rtl/prim_flop_en.sv
// Enable-gated register with asynchronous active-low reset to a parameterised value.
module prim_flop_en #(
  parameter int unsigned     Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= ResetValue;
    end else if (en_i) begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule : prim_flop_en

// File: rtl/prim_reg_slice.sv
// Full-throughput valid/ready register slice with a main register and a skid register.
// All handshake flags and depth decode purely from the state register.
module prim_reg_slice
  import prim_reg_slice_pkg::*;
#(
  parameter int unsigned      Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [Width-1:0]  in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [Width-1:0]  out_data_o,
  output logic [DepthW-1:0] depth_o
);

  slice_state_e r_state;
  slice_state_e w_state_next;

  logic              w_in_fire;
  logic              w_out_fire;
  logic              w_main_en;
  logic              w_skid_en;
  logic [Width-1:0]  w_main_d;
  logic [Width-1:0]  w_skid_d;
  logic [Width-1:0]  w_main_q;
  logic [Width-1:0]  w_skid_q;
  logic              w_in_ready;
  logic              w_out_valid;
  logic [DepthW-1:0] w_depth;

  assign w_in_fire  = in_valid_i & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready_i;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= SliceEmpty;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Flag decode from the current state only.
  always_comb begin
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    w_depth     = DepthW'(0);
    unique case (r_state)
      SliceEmpty: begin
        w_in_ready = 1'b1;
      end
      SliceOne: begin
        w_in_ready  = 1'b1;
        w_out_valid = 1'b1;
        w_depth     = DepthW'(1);
      end
      SliceFull: begin
        w_out_valid = 1'b1;
        w_depth     = DepthW'(SliceDepth);
      end
      default: ;
    endcase
  end

  // Next state and data-register load enables; clear overrides any handshake.
  always_comb begin
    w_state_next = r_state;
    w_main_en    = 1'b0;
    w_skid_en    = 1'b0;
    w_main_d     = in_data_i;
    w_skid_d     = in_data_i;
    if (clr_i) begin
      w_state_next = SliceEmpty;
      w_main_en    = 1'b1;
      w_skid_en    = 1'b1;
      w_main_d     = ResetValue;
      w_skid_d     = ResetValue;
    end else begin
      unique case (r_state)
        SliceEmpty: begin
          if (w_in_fire) begin
            w_main_en    = 1'b1;
            w_state_next = SliceOne;
          end
        end
        SliceOne: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire) begin
            w_skid_en    = 1'b1;
            w_state_next = SliceFull;
          end else if (w_out_fire) begin
            w_state_next = SliceEmpty;
          end
        end
        SliceFull: begin
          if (w_out_fire) begin
            w_main_en    = 1'b1;
            w_main_d     = w_skid_q;
            w_state_next = SliceOne;
          end
        end
        default: begin
          w_state_next = SliceEmpty;
        end
      endcase
    end
  end

  prim_flop_en #(
    .Width      (Width),
    .ResetValue (ResetValue)
  ) u_main (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_main_en),
    .d_i    (w_main_d),
    .q_o    (w_main_q)
  );

  prim_flop_en #(
    .Width      (Width),
    .ResetValue (ResetValue)
  ) u_skid (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .en_i   (w_skid_en),
    .d_i    (w_skid_d),
    .q_o    (w_skid_q)
  );

  assign in_ready_o  = w_in_ready;
  assign out_valid_o = w_out_valid;
  assign out_data_o  = w_main_q;
  assign depth_o     = w_depth;

endmodule : prim_reg_slice

// File: tb/tb_prim_reg_slice.sv
// Directed and scoreboarded random checks for prim_reg_slice.
module tb_prim_reg_slice;

  localparam int unsigned W = 32;

  logic         clk;
  logic         rst_n;
  logic         clr;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   depth;

  int total = 0;
  int bad   = 0;

  prim_reg_slice #(.Width(W), .ResetValue('0)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (clr),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_data_i   (in_data),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .depth_o     (depth)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step();
    total++;
    if (out_valid !== 1'b0 || depth !== 2'd0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset: valid=%b depth=%0d data=%h ready=%b, want 0 0 0 1",
               out_valid, depth, out_data, in_ready);
    end
  endtask

  task automatic test_first_beat();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'hA5A5_0001; out_ready = 1'b1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL first_ready: got %b want 1", in_ready);
    end
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'hA5A5_0001 || depth !== 2'd1 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL first_beat: valid=%b data=%h depth=%0d ready=%b, want 1 a5a50001 1 1",
               out_valid, out_data, depth, in_ready);
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || depth !== 2'd0) begin
      bad++; $display("FAIL first_drain: valid=%b depth=%0d, want 0 0", out_valid, depth);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      in_valid = 1'b1; in_data = W'(k);
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== W'(k) || depth !== 2'd1 || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d: valid=%b data=%h depth=%0d ready=%b, want 1 %h 1 1",
                 k, out_valid, out_data, depth, in_ready, W'(k));
      end
    end
    in_valid = 1'b0;
    step();
    total++;
    if (out_valid !== 1'b0 || depth !== 2'd0) begin
      bad++; $display("FAIL b2b_drain: valid=%b depth=%0d, want 0 0", out_valid, depth);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h11;
    step();
    total++;
    if (depth !== 2'd1 || in_ready !== 1'b1 || out_data !== 32'h11) begin
      bad++; $display("FAIL bp_one: depth=%0d ready=%b data=%h, want 1 1 11", depth, in_ready, out_data);
    end
    in_data = 32'h22;
    step();
    total++;
    if (depth !== 2'd2 || in_ready !== 1'b0 || out_data !== 32'h11 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_full: depth=%0d ready=%b data=%h valid=%b, want 2 0 11 1",
                      depth, in_ready, out_data, out_valid);
    end
    in_data = 32'h33;
    step();
    total++;
    if (depth !== 2'd2 || out_data !== 32'h11 || out_valid !== 1'b1) begin
      bad++; $display("FAIL bp_hold: depth=%0d data=%h valid=%b, want 2 11 1", depth, out_data, out_valid);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (depth !== 2'd1 || out_data !== 32'h22 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_pop1: depth=%0d data=%h ready=%b, want 1 22 1", depth, out_data, in_ready);
    end
    step();
    total++;
    if (depth !== 2'd1 || out_data !== 32'h33) begin
      bad++; $display("FAIL bp_pop2: depth=%0d data=%h, want 1 33", depth, out_data);
    end
    in_valid = 1'b0;
    step();
    total++;
    if (depth !== 2'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL bp_empty: depth=%0d valid=%b, want 0 0", depth, out_valid);
    end
  endtask

  task automatic test_clear();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h44;
    step();
    in_data = 32'h55;
    step();
    total++;
    if (depth !== 2'd2) begin
      bad++; $display("FAIL clr_fill: depth=%0d want 2", depth);
    end
    clr = 1'b1; in_data = 32'h66;
    step();
    total++;
    if (depth !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL clr_flush: depth=%0d valid=%b data=%h ready=%b, want 0 0 0 1",
                      depth, out_valid, out_data, in_ready);
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b0 || out_data === 32'h66) begin
      bad++; $display("FAIL clr_drop: valid=%b data=%h, want 0 and not 66", out_valid, out_data);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h88;
    step();
    in_data = 32'h99;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || depth !== 2'd0 || out_data !== 32'h0) begin
      bad++; $display("FAIL arst_now: valid=%b depth=%0d data=%h, want 0 0 0", out_valid, depth, out_data);
    end
    #1;
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b1;
    step();
    total++;
    if (out_valid !== 1'b1 || out_data !== 32'h77 || depth !== 2'd1) begin
      bad++; $display("FAIL arst_beat: valid=%b data=%h depth=%0d, want 1 77 1", out_valid, out_data, depth);
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] q[$];
    logic [W-1:0] exp_v;
    logic [W-1:0] prev_data;
    logic         prev_stall;
    logic [W-1:0] next_val;
    int           errs;
    errs = 0;
    next_val = 32'h1000_0000;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 10000; c++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_data   = next_val;
      if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data)) begin
        errs++;
        if (errs < 5) $display("FAIL rand_stable: cyc=%0d valid=%b data=%h want 1 %h",
                               c, out_valid, out_data, prev_data);
      end
      if (depth !== 2'(q.size())) begin
        errs++;
        if (errs < 5) $display("FAIL rand_depth: cyc=%0d depth=%0d want %0d", c, depth, q.size());
      end
      if (out_valid && out_ready) begin
        exp_v = q.pop_front();
        if (out_data !== exp_v) begin
          errs++;
          if (errs < 5) $display("FAIL rand_data: cyc=%0d data=%h want %h", c, out_data, exp_v);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(next_val);
        next_val = next_val + 32'd1;
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    while (q.size() != 0 && out_valid === 1'b1) begin
      exp_v = q.pop_front();
      if (out_data !== exp_v) begin
        errs++; $display("FAIL rand_drain: data=%h want %h", out_data, exp_v);
      end
      step();
    end
    total++;
    if (errs != 0 || q.size() != 0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL rand_scoreboard: errors=%0d leftover=%0d valid=%b, want 0 0 0", errs, q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_first_beat();
    test_back_to_back();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_prim_reg_slice

// File: doc/prim_reg_slice.md
Name: prim_reg_slice

Overview:
- Full-throughput valid/ready register slice with a two-entry skid store.
- Breaks the combinational ready and data paths between a producer and a consumer, such as a datapath stage feeding OTBN's flop-based pipeline registers.
- Sits directly upstream of the plain flop stage. It adds backpressure handling that the bare flop lacks, so timing cut points can be inserted on handshaked buses.

Parameters:
- Width, 32, data bits per transfer.
- ResetValue, '0, value loaded into both data registers on reset and on clear.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_ni  input  1  reset; asynchronous assert, active-low.
- clr_i  input  1  synchronous flush; drops all held data.
- in_valid_i  input  1  producer offers in_data_i.
- in_ready_o  output  1  slice accepts; transfer when in_valid_i & in_ready_o.
- in_data_i  input  Width  producer data.
- out_valid_o  output  1  out_data_o holds valid data.
- out_ready_i  input  1  consumer accepts; transfer when out_valid_o & out_ready_i.
- out_data_o  output  Width  data at the head of the slice.
- depth_o  output  2  current occupancy, 0..2.

Behaviour:
- Storage: main register (drives out_data_o) and skid register. The state register is the only source of in_ready_o, out_valid_o and depth_o; there is no combinational path from any input to any output.
- States and flags:
  - EMPTY: depth 0, out_valid_o=0, in_ready_o=1.
  - ONE: depth 1, out_valid_o=1, in_ready_o=1.
  - FULL: depth 2, out_valid_o=1, in_ready_o=0.
  - Illegal encoding: go to EMPTY.
- Transitions, with in_fire = in_valid_i & in_ready_o and out_fire = out_valid_o & out_ready_i:
  - EMPTY, in_fire: main<=in_data_i, go to ONE.
  - ONE, in_fire & !out_fire: skid<=in_data_i, go to FULL.
  - ONE, in_fire & out_fire: main<=in_data_i, stay in ONE. Sustains 1 transfer/cycle.
  - ONE, !in_fire & out_fire: go to EMPTY.
  - FULL, out_fire: main<=skid, go to ONE. No input is accepted, since in_ready_o=0.
  - All other cases: hold.
- Latency: data accepted in cycle N appears on out_data_o with out_valid_o=1 in cycle N+1.
- Ordering: strict FIFO order. Nothing is dropped or duplicated.
- Stability: while out_valid_o & !out_ready_i, out_data_o and out_valid_o hold unchanged.
- in_valid_i while in_ready_o=0 has no effect. The producer must hold its data; the slice does not check this.
- Reset (rst_ni low, at any time including mid-transfer):
  - Immediately: state EMPTY, main=skid=ResetValue, out_valid_o=0, depth_o=0.
  - in_ready_o=1 from the first rising edge after rst_ni deasserts.
- clr_i:
  - Next edge: state EMPTY and both registers loaded with ResetValue, whatever the handshake inputs.
  - clr_i takes priority over a simultaneous in_fire; that input beat is discarded.
  - A simultaneous out_fire completes on the consumer side with the pre-clear data.
- Data registers update only on a load condition, which keeps idle power low. Data values must not affect control.

Decomposition:
- Package prim_reg_slice_pkg:
  - typedef enum logic [1:0] slice_state_e {SliceEmpty=2'b00, SliceOne=2'b01, SliceFull=2'b11}.
  - Constant SliceDepth = 2.
- Sub-module prim_flop_en:
  - Width/ResetValue parameters, async active-low reset, enable input.
  - Instantiated twice, for main and skid.
- Control FSM stays inline.

Test Plan:
- Reset release, in_valid_i=1, data 0xA5A5_0001, out_ready_i=1 -> out_valid_o=1 and out_data_o=0xA5A5_0001 next cycle; in_ready_o=1 throughout; depth_o=1.
- Stream 0x1..0x10 back-to-back, out_ready_i tied 1 -> 16 outputs on 16 consecutive cycles in order; depth_o never reaches 2.
- Send 0x11, 0x22, 0x33 with out_ready_i=0 -> in_ready_o drops after the second accept; depth_o=2; out_data_o holds 0x11. Then raise out_ready_i -> outputs 0x11, 0x22, 0x33 in order, and 0x33 is accepted only once in_ready_o returns.
- FULL with 0x44, 0x55; pulse clr_i with in_valid_i=1 and data 0x66 -> next cycle depth_o=0, out_valid_o=0, out_data_o=ResetValue; 0x66 never appears.
- Assert rst_ni low asynchronously mid-cycle while FULL -> out_valid_o=0 and depth_o=0 before the next clock edge; after release, a new beat 0x77 passes with 1-cycle latency.
- Random valid/ready at 50% duty for 10k cycles against a scoreboard -> no loss, duplication or reordering; out_data_o stable whenever out_valid_o & !out_ready_i.
